fwd_ctrl_unit: RTL and testbench

FWD_CTRL_UNIT -- requirements
Module: fwd_ctrl_unit

---
 rtl/fwd_ctrl_unit_pkg.sv | 29 ++
 rtl/fwd_ctrl_unit_cmp.sv | 21 ++
 rtl/fwd_ctrl_unit.sv | 97 +++++++++
 tb/tb_fwd_ctrl_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared pipeline definitions for the forwarding/hazard control unit:
// register index width, forward-select encodings and the destination slot record.
package fwd_ctrl_unit_pkg;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic     wr_en;
        reg_idx_t wr_reg;
        logic     is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{wr_en: 1'b0, wr_reg: '0, is_load: 1'b0};

    // True when the slot will write register r; r0 is hardwired and never a producer.
    function automatic logic slot_writes(input slot_t s, input reg_idx_t r);
        return s.wr_en && (s.wr_reg == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_ctrl_unit_cmp.sv
// Per-operand forward select: picks MEM, then WB, then the register file.
module fwd_cmp
    import fwd_ctrl_unit_pkg::*;
(
    input  reg_idx_t    reg_i,
    input  slot_t       mem_i,
    input  slot_t       wb_i,
    output logic [1:0]  sel_o
);

    // A load in MEM has no data yet; its consumer was already held back by a stall.
    always_comb begin
        sel_o = SEL_RF;
        if (slot_writes(mem_i, reg_i) && !mem_i.is_load) begin
            sel_o = SEL_MEM;
        end else if (slot_writes(wb_i, reg_i)) begin
            sel_o = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding and load-use hazard control: tracks the ex/mem/wb destination
// slots, raises a one-cycle stall on load-use, and counts stall cycles.
module fwd_ctrl_unit
    import fwd_ctrl_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] exe_fwd_reg,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       fwd_c_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t              ex_q, ex_d;
    slot_t              mem_q;
    slot_t              wb_q;
    reg_idx_t           ex_rs_q, ex_rs_d;
    reg_idx_t           ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               load_use;

    always_comb begin
        load_use = ex_q.is_load && ex_q.wr_en && (ex_q.wr_reg != '0) &&
                   ((ex_q.wr_reg == id_rs) || (ex_q.wr_reg == id_rt));
    end

    // A killed ID instruction never needs to wait, so flush masks the stall.
    assign stall = load_use && !flush;

    always_comb begin
        ex_d    = '{wr_en: id_wr_en, wr_reg: id_wr_reg, is_load: id_is_load};
        ex_rs_d = id_rs;
        ex_rt_d = id_rt;
        if (stall || flush) begin
            ex_d    = SLOT_BUBBLE;
            ex_rs_d = '0;
            ex_rt_d = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= SLOT_BUBBLE;
            mem_q       <= SLOT_BUBBLE;
            wb_q        <= SLOT_BUBBLE;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    fwd_cmp u_cmp_a (
        .reg_i (ex_rs_q),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (fwd_a_sel)
    );

    fwd_cmp u_cmp_b (
        .reg_i (ex_rt_q),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (fwd_b_sel)
    );

    fwd_cmp u_cmp_c (
        .reg_i (exe_fwd_reg),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (fwd_c_sel)
    );

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed bench for fwd_ctrl_unit: expected {stall, a, b, c, cnt} vectors are
// queued as each input set is driven and compared half a cycle later.
module tb_fwd_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_wr_en;
    logic [2:0]  id_wr_reg;
    logic        id_is_load;
    logic [2:0]  exe_fwd_reg;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [1:0]  fwd_c_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [22:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    fwd_ctrl_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_is_load  (id_is_load),
        .exe_fwd_reg (exe_fwd_reg),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .fwd_c_sel   (fwd_c_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_inputs(input logic [2:0] rs, input logic [2:0] rt, input logic wen,
                              input logic [2:0] wreg, input logic ld, input logic [2:0] fr,
                              input logic fl);
        id_rs       = rs;
        id_rt       = rt;
        id_wr_en    = wen;
        id_wr_reg   = wreg;
        id_is_load  = ld;
        exe_fwd_reg = fr;
        flush       = fl;
    endtask

    task automatic push_exp(input logic es, input logic [1:0] ea, input logic [1:0] eb,
                            input logic [1:0] ec, input logic [15:0] ecnt);
        exp_q.push_back({es, ea, eb, ec, ecnt});
    endtask

    task automatic check(input string tag);
        logic [22:0] obs;
        logic [22:0] exp_v;
        #1;
        obs   = {stall, fwd_a_sel, fwd_b_sel, fwd_c_sel, stall_cnt};
        exp_v = exp_q.pop_front();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed stall=%b a=%b b=%b c=%b cnt=%h, expected stall=%b a=%b b=%b c=%b cnt=%h",
                   tag, obs[22], obs[21:20], obs[19:18], obs[17:16], obs[15:0],
                   exp_v[22], exp_v[21:20], exp_v[19:18], exp_v[17:16], exp_v[15:0]);
        end
    endtask

    // Drive one ID cycle at the falling edge, check mid-low-phase, advance one clock.
    task automatic step(input string tag,
                        input logic [2:0] rs, input logic [2:0] rt, input logic wen,
                        input logic [2:0] wreg, input logic ld, input logic [2:0] fr,
                        input logic fl,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb,
                        input logic [1:0] ec, input logic [15:0] ecnt);
        set_inputs(rs, rt, wen, wreg, ld, fr, fl);
        push_exp(es, ea, eb, ec, ecnt);
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        int sat;
        rst_n = 1'b0;
        set_inputs(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        step("reset_idle",        0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        rst_n = 1'b1;

        // ADD r3 then SUB r3: MEM forward on rs, and on the third operand
        step("add_r3_id",         1, 2, 1, 3, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("sub_r3_id",         3, 4, 1, 6, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("sub_exe_mem_fwd",   0, 0, 0, 0, 0, 3, 0,  0, 2'b01, 2'b00, 2'b01, 16'd0);
        step("wb_r3_on_c",        0, 0, 0, 0, 0, 3, 0,  0, 2'b00, 2'b00, 2'b10, 16'd0);

        // ADD r3, unrelated, reader of r3: WB forward on rs
        step("add_r3_again",      0, 0, 1, 3, 0, 6, 0,  0, 2'b00, 2'b00, 2'b10, 16'd0);
        step("unrelated",         1, 1, 1, 4, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("reader_id",         3, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("reader_exe_wb_fwd", 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 2'b00, 16'd0);

        // Two writers of r5 in mem and wb: MEM wins on rt
        step("w5_first",          0, 0, 1, 5, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("w5_second",         0, 0, 1, 5, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("r5_id",             0, 5, 0, 0, 0, 5, 0,  0, 2'b00, 2'b00, 2'b01, 16'd0);
        step("r5_exe_mem_prio",   0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b01, 2'b00, 16'd0);
        step("r5_wb_on_c",        0, 0, 0, 0, 0, 5, 0,  0, 2'b00, 2'b00, 2'b10, 16'd0);

        // Writer of r0 then reader of r0: never forwarded
        step("w_r0",              0, 0, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("r0_id",             0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("r0_mem_no_fwd",     0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("r0_wb_no_fwd",      0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);

        // LW r2 then consumer of r2: one stall, load in MEM not forwarded, then WB forward
        step("lw_r2_id",          0, 0, 1, 2, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);
        step("load_use_stall",    2, 0, 1, 7, 0, 0, 0,  1, 2'b00, 2'b00, 2'b00, 16'd0);
        step("bubble_after_stall",2, 0, 1, 7, 0, 2, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        step("consumer_wb_fwd",   0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 2'b00, 16'd1);

        // Same hazard on rt with flush: no stall, no count, flushed writer never reaches mem
        step("lw_r2_again",       0, 0, 1, 2, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        step("flush_beats_stall", 0, 2, 1, 6, 0, 0, 1,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        step("flush_cnt_held",    0, 0, 0, 0, 0, 6, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        step("flushed_not_in_mem",0, 0, 0, 0, 0, 6, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);

        // Build a live stall plus a MEM forward, then pull reset between clock edges
        step("add_r4_id",         0, 0, 1, 4, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        step("lw_r2_id_2",        0, 0, 1, 2, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd1);
        set_inputs(3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0);
        push_exp(1'b1, 2'b00, 2'b00, 2'b01, 16'd1);
        check("pre_reset_stall");
        rst_n = 1'b0;
        push_exp(1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
        check("async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset",        0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'd0);

        // Counter increments once per hazard
        for (int k = 0; k < 3; k++) begin
            step("cnt_ld_issue",  0, 0, 1, 2, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'(k));
            step("cnt_ld_stall",  2, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 2'b00, 16'(k));
        end

        // Preload the counter near the top instead of replaying ~65k hazards
        set_inputs(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        force dut.stall_cnt_q = 16'hFFFB;
        @(negedge clk);
        release dut.stall_cnt_q;
        for (int k = 0; k < 7; k++) begin
            sat = 'hFFFB + k;
            if (sat > 'hFFFF) sat = 'hFFFF;
            step("sat_ld_issue",  0, 0, 1, 2, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'(sat));
            step("sat_ld_stall",  2, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 2'b00, 16'(sat));
        end
        step("sat_hold",          0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
